// File: rtl/u409_pci_cycle_sequencer.sv
// rtl/u409_pci_cycle_sequencer.sv - 68040-to-PCI single-beat master cycle sequencer
// Turns a decoded 68040 transfer into a PCI address/data cycle with retry and abort handling.
`timescale 1ns/1ps
module u409_pci_cycle_sequencer #(
    parameter int DEVSEL_TIMEOUT = 5,
    parameter int RETRY_LIMIT    = 15
) (
    input  logic       CLK40,
    input  logic       RESET,
    input  logic       TSn,
    input  logic       RWn,
    input  logic       BRIDGE_ENn,
    input  logic       BRIDGE_REG_SPACE,
    input  logic [1:0] PCIAT,
    input  logic       DEVSELn,
    input  logic       TRDYn,
    input  logic       STOPn,
    output logic       FRAMEn,
    output logic       IRDYn,
    output logic       AD_OE,
    output logic [3:0] PCI_CMD,
    output logic       TAn,
    output logic       TEAn,
    output logic       REG_SEL,
    output logic       BUSY
);

    localparam int DW = $clog2(DEVSEL_TIMEOUT + 2);
    localparam int RW = $clog2(RETRY_LIMIT + 2);

    typedef enum logic [2:0] {
        IDLE, ADDR, DATA, RETRY, TURN, REG1, REG2
    } state_t;

    state_t        state;
    logic [DW-1:0] devsel_cnt;
    logic [RW-1:0] retry_cnt;

    function automatic logic [3:0] encode_cmd(input logic [1:0] at, input logic rw);
        case (at)
            2'b10:   encode_cmd = {3'b011, ~rw};
            2'b11:   encode_cmd = {3'b001, ~rw};
            default: encode_cmd = {3'b101, ~rw};
        endcase
    endfunction

    always_ff @(posedge CLK40) begin
        if (RESET) begin
            state      <= IDLE;
            devsel_cnt <= '0;
            retry_cnt  <= '0;
            FRAMEn     <= 1'b1;
            IRDYn      <= 1'b1;
            AD_OE      <= 1'b0;
            PCI_CMD    <= 4'b0000;
            TAn        <= 1'b1;
            TEAn       <= 1'b1;
            REG_SEL    <= 1'b0;
            BUSY       <= 1'b0;
        end else begin
            TAn  <= 1'b1;
            TEAn <= 1'b1;
            case (state)
                IDLE: begin
                    if (!TSn && !BRIDGE_ENn) begin
                        BUSY <= 1'b1;
                        if (BRIDGE_REG_SPACE) begin
                            state   <= REG1;
                            REG_SEL <= 1'b1;
                        end else begin
                            // PCI_CMD doubles as the latched command for re-issued retries
                            state   <= ADDR;
                            FRAMEn  <= 1'b0;
                            AD_OE   <= 1'b1;
                            PCI_CMD <= encode_cmd(PCIAT, RWn);
                        end
                    end
                end
                ADDR: begin
                    state      <= DATA;
                    FRAMEn     <= 1'b1;
                    IRDYn      <= 1'b0;
                    AD_OE      <= 1'b0;
                    devsel_cnt <= '0;
                end
                DATA: begin
                    // Counter reads 0 on the first DATA clock, so an abort takes DEVSEL_TIMEOUT+1 clocks
                    if (!TRDYn) begin
                        state <= TURN;
                        IRDYn <= 1'b1;
                        TAn   <= 1'b0;
                    end else if (!STOPn) begin
                        IRDYn <= 1'b1;
                        if (retry_cnt < RW'(RETRY_LIMIT)) begin
                            state     <= RETRY;
                            retry_cnt <= retry_cnt + 1'b1;
                        end else begin
                            state <= TURN;
                            TEAn  <= 1'b0;
                        end
                    end else if (DEVSELn && devsel_cnt == DW'(DEVSEL_TIMEOUT)) begin
                        state <= TURN;
                        IRDYn <= 1'b1;
                        TEAn  <= 1'b0;
                    end else if (devsel_cnt != DW'(DEVSEL_TIMEOUT)) begin
                        devsel_cnt <= devsel_cnt + 1'b1;
                    end
                end
                RETRY: begin
                    state  <= ADDR;
                    FRAMEn <= 1'b0;
                    AD_OE  <= 1'b1;
                end
                TURN: begin
                    state     <= IDLE;
                    BUSY      <= 1'b0;
                    retry_cnt <= '0;
                    PCI_CMD   <= 4'b0000;
                end
                REG1: begin
                    state <= REG2;
                    TAn   <= 1'b0;
                end
                REG2: begin
                    state     <= IDLE;
                    REG_SEL   <= 1'b0;
                    BUSY      <= 1'b0;
                    retry_cnt <= '0;
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_u409_pci_cycle_sequencer.sv
// tb/tb_u409_pci_cycle_sequencer.sv - scoreboard bench for the PCI cycle sequencer
`timescale 1ns/1ps
module tb_u409_pci_cycle_sequencer;

    localparam int DEVSEL_TIMEOUT = 5;
    localparam int RETRY_LIMIT    = 15;
    localparam int R_TA = 0, R_STOP = 1, R_BOTH = 2, R_ABORT = 3;

    logic       CLK40 = 1'b0;
    logic       RESET, TSn, RWn, BRIDGE_ENn, BRIDGE_REG_SPACE;
    logic [1:0] PCIAT;
    logic       DEVSELn, TRDYn, STOPn;
    logic       FRAMEn, IRDYn, AD_OE, TAn, TEAn, REG_SEL, BUSY;
    logic [3:0] PCI_CMD;

    typedef struct {
        logic       ta;
        logic [3:0] cmd;
        int         addr;
        int         data;
        int         regc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    int         addr_cnt, oe_cnt, data_cnt, reg_cnt;
    logic [3:0] cmd_seen;
    bit         cmd_changed, prev_pulse, pulse;

    u409_pci_cycle_sequencer #(
        .DEVSEL_TIMEOUT(DEVSEL_TIMEOUT),
        .RETRY_LIMIT(RETRY_LIMIT)
    ) dut (
        .CLK40(CLK40), .RESET(RESET), .TSn(TSn), .RWn(RWn),
        .BRIDGE_ENn(BRIDGE_ENn), .BRIDGE_REG_SPACE(BRIDGE_REG_SPACE), .PCIAT(PCIAT),
        .DEVSELn(DEVSELn), .TRDYn(TRDYn), .STOPn(STOPn),
        .FRAMEn(FRAMEn), .IRDYn(IRDYn), .AD_OE(AD_OE), .PCI_CMD(PCI_CMD),
        .TAn(TAn), .TEAn(TEAn), .REG_SEL(REG_SEL), .BUSY(BUSY)
    );

    always #5 CLK40 = ~CLK40;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_xfer(input logic ta, input logic [3:0] cmd, input int addr,
                               input int data, input int regc);
        exp_t e;
        e.ta = ta; e.cmd = cmd; e.addr = addr; e.data = data; e.regc = regc;
        sb_q.push_back(e);
    endtask

    task automatic clear_mon();
        addr_cnt = 0; oe_cnt = 0; data_cnt = 0; reg_cnt = 0;
        cmd_seen = 4'h0; cmd_changed = 1'b0;
    endtask

    initial begin
        clear_mon();
        prev_pulse = 1'b0;
        forever begin
            @(negedge CLK40);
            if (RESET === 1'b1) begin
                clear_mon();
                prev_pulse = 1'b0;
            end else begin
                if (FRAMEn === 1'b0) begin
                    if (addr_cnt == 0) cmd_seen = PCI_CMD;
                    else if (PCI_CMD !== cmd_seen) cmd_changed = 1'b1;
                    addr_cnt++;
                    data_cnt = 0;
                end
                if (AD_OE === 1'b1) oe_cnt++;
                if (IRDYn === 1'b0) data_cnt++;
                if (REG_SEL === 1'b1) reg_cnt++;
                pulse = (TAn === 1'b0) || (TEAn === 1'b0);
                if (prev_pulse) begin
                    check("ack_width", {TAn, TEAn}, 2'b11);
                    check("busy_after_ack", BUSY, 1'b0);
                end else if (pulse) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_ack", {TAn, TEAn}, 2'b11);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        check("ack_kind", {TAn, TEAn}, e.ta ? 2'b01 : 2'b10);
                        check("addr_phases", addr_cnt, e.addr);
                        check("ad_oe_cycles", oe_cnt, e.addr);
                        if (e.addr > 0) begin
                            check("pci_cmd", cmd_seen, e.cmd);
                            check("cmd_stable", cmd_changed, 1'b0);
                        end
                        check("data_cycles", data_cnt, e.data);
                        check("reg_sel_cycles", reg_cnt, e.regc);
                    end
                    clear_mon();
                end
                prev_pulse = pulse;
            end
        end
    end

    task automatic check_reset(input string p);
        check({p, "_framen"}, FRAMEn, 1'b1);
        check({p, "_irdyn"}, IRDYn, 1'b1);
        check({p, "_tan"}, TAn, 1'b1);
        check({p, "_tean"}, TEAn, 1'b1);
        check({p, "_ad_oe"}, AD_OE, 1'b0);
        check({p, "_reg_sel"}, REG_SEL, 1'b0);
        check({p, "_busy"}, BUSY, 1'b0);
        check({p, "_pci_cmd"}, PCI_CMD, 4'b0000);
    endtask

    task automatic start_cycle(input logic [1:0] at, input logic rw, input logic rs);
        PCIAT = at; RWn = rw; BRIDGE_REG_SPACE = rs; TSn = 1'b0; BRIDGE_ENn = 1'b0;
        @(posedge CLK40); #1;
        TSn = 1'b1; BRIDGE_ENn = 1'b1; BRIDGE_REG_SPACE = 1'b0;
    endtask

    task automatic wait_irdy(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (IRDYn === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(posedge CLK40); #1;
        end
        if (!ok) check("irdy_timeout", IRDYn, 1'b0);
    endtask

    task automatic respond(input int kind, input int delay);
        bit ok;
        wait_irdy(ok);
        if (!ok) return;
        if (kind == R_ABORT) begin
            for (int i = 0; i < 20 && IRDYn === 1'b0; i++) begin
                @(posedge CLK40); #1;
            end
            if (IRDYn !== 1'b1) check("abort_timeout", IRDYn, 1'b1);
            return;
        end
        DEVSELn = 1'b0;
        repeat (delay) begin
            @(posedge CLK40); #1;
        end
        TRDYn = (kind == R_STOP);
        STOPn = (kind == R_TA);
        @(posedge CLK40); #1;
        DEVSELn = 1'b1; TRDYn = 1'b1; STOPn = 1'b1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (BUSY !== 1'b0 && n < 50) begin
            @(posedge CLK40); #1;
            n++;
        end
        if (BUSY !== 1'b0) check("idle_timeout", BUSY, 1'b0);
        repeat (2) begin
            @(posedge CLK40); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        bit ok;
        RESET = 1'b1; TSn = 1'b1; RWn = 1'b1; BRIDGE_ENn = 1'b1; BRIDGE_REG_SPACE = 1'b0;
        PCIAT = 2'b00; DEVSELn = 1'b1; TRDYn = 1'b1; STOPn = 1'b1;
        repeat (3) @(posedge CLK40);
        #1;
        check_reset("reset");
        RESET = 1'b0;
        @(posedge CLK40); #1;

        // TSn with bridge not selected is ignored
        TSn = 1'b0; BRIDGE_ENn = 1'b1;
        @(posedge CLK40); #1;
        check("bridge_en_ignored", BUSY, 1'b0);
        TSn = 1'b1;
        @(posedge CLK40); #1;

        // memory read, TRDYn on 2nd DATA clock
        expect_xfer(1'b1, 4'b0110, 1, 2, 0);
        start_cycle(2'b10, 1'b1, 1'b0);
        check("addr_framen", FRAMEn, 1'b0);
        respond(R_TA, 1);
        check("ta_latency", TAn, 1'b0);
        wait_idle();

        // config write, TRDYn and STOPn together -> TAn
        expect_xfer(1'b1, 4'b1011, 1, 1, 0);
        start_cycle(2'b01, 1'b0, 1'b0);
        respond(R_BOTH, 0);
        wait_idle();

        // master abort
        expect_xfer(1'b0, 4'b1010, 1, DEVSEL_TIMEOUT + 1, 0);
        start_cycle(2'b00, 1'b1, 1'b0);
        respond(R_ABORT, 0);
        wait_idle();

        // three retries then TRDYn
        expect_xfer(1'b1, 4'b0011, 4, 1, 0);
        start_cycle(2'b11, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) respond(R_STOP, 0);
        respond(R_TA, 0);
        wait_idle();

        // retry limit exhausted
        expect_xfer(1'b0, 4'b0111, RETRY_LIMIT + 1, 1, 0);
        start_cycle(2'b10, 1'b0, 1'b0);
        for (int i = 0; i < RETRY_LIMIT + 1; i++) respond(R_STOP, 0);
        wait_idle();

        // retry count cleared after previous cycle
        expect_xfer(1'b1, 4'b0010, 2, 3, 0);
        start_cycle(2'b11, 1'b1, 1'b0);
        respond(R_STOP, 0);
        respond(R_TA, 2);
        wait_idle();

        // register space access
        expect_xfer(1'b1, 4'b0000, 0, 0, 2);
        start_cycle(2'b10, 1'b1, 1'b1);
        check("reg1_reg_sel", REG_SEL, 1'b1);
        wait_idle();

        // TSn while busy is ignored
        expect_xfer(1'b1, 4'b0110, 1, 4, 0);
        start_cycle(2'b10, 1'b1, 1'b0);
        wait_irdy(ok);
        DEVSELn = 1'b0;
        TSn = 1'b0; BRIDGE_ENn = 1'b0; BRIDGE_REG_SPACE = 1'b1;
        repeat (3) begin
            @(posedge CLK40); #1;
        end
        TRDYn = 1'b0; TSn = 1'b1; BRIDGE_ENn = 1'b1; BRIDGE_REG_SPACE = 1'b0;
        @(posedge CLK40); #1;
        TRDYn = 1'b1; DEVSELn = 1'b1;
        wait_idle();
        check("busy_ts_ignored", BUSY, 1'b0);

        // reset in DATA abandons the cycle
        start_cycle(2'b10, 1'b1, 1'b0);
        wait_irdy(ok);
        DEVSELn = 1'b0;
        RESET = 1'b1;
        @(posedge CLK40); #1;
        check_reset("data_reset");
        RESET = 1'b0; DEVSELn = 1'b1;
        repeat (4) begin
            @(posedge CLK40); #1;
        end
        check("post_reset_idle", BUSY, 1'b0);

        check("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
